bsg_link_credit_sched: RTL and testbench
========================================

Name: bsg_link_credit_sched

Overview:
- Credit-based scheduler in front of the DDR link upstream channel.
- Shares one link channel between NUM_CH core-side requesters using round-robin arbitration.
- Sends a beat only when the downstream buffer has room, tracked as credits replenished by the downstream token line (core_token_r_o, already synchronised into clk).
- Output is a one-entry registered stage so link_v_o/link_data_o are glitch-free for the link.

Parameters:
- NUM_CH, 4, number of requesters (2..8)
- DW, 16, payload width per beat
- CREDITS, 32, downstream buffer depth in beats; reset credit count
- DECIMATION, 4, credits returned per token toggle
- CW, 6, credit counter width (must hold CREDITS; 6 for defaults)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, async active-low
- req_v_i  in  NUM_CH  per-channel request valid
- req_data_i  in  NUM_CH*DW  per-channel payload, channel i at [i*DW +: DW]
- req_yumi_o  out  NUM_CH  one-hot accept; request is consumed this cycle
- link_v_o  out  1  output beat valid (registered)
- link_data_o  out  DW  output payload (registered)
- link_ch_o  out  $clog2(NUM_CH)  source channel of output beat (registered)
- link_ready_i  in  1  link accepts beat when link_v_o & link_ready_i
- token_i  in  1  synchronised downstream token; each toggle returns DECIMATION credits
- credits_o  out  CW  current credit count
- overflow_o  out  1  sticky credit-overflow error

Behaviour:
- Reset values (async, rst_n=0):
  - link_v_o=0, link_data_o=0, link_ch_o=0, req_yumi_o=0.
  - credits_o=CREDITS, overflow_o=0, rr pointer=0, token edge register=token_i sampled at first clock after release.
  - Reset asserted mid-transfer discards the held beat; no beat is delivered to the link during reset.
- Token:
  - tok_q <= token_i each cycle.
  - ret = (token_i ^ tok_q) ? DECIMATION : 0.
  - Both edges count.
- Load condition: slot_free = ~link_v_o | link_ready_i; can_load = slot_free & (credits_o != 0) & |req_v_i.
- Arbitration:
  - Combinational round-robin starting at pointer p; grant is the first i ≥ p (mod NUM_CH) with req_v_i[i].
  - req_yumi_o = grant & {NUM_CH{can_load}}.
  - On load: p <= grant_idx+1 (wraps NUM_CH-1 → 0). p is unchanged when no load occurs.
- Output register:
  - On load: link_v_o<=1, link_data_o<=req_data_i[grant], link_ch_o<=grant_idx.
  - Else if link_ready_i: link_v_o<=0. Else hold all fields stable.
  - Zero-bubble: with continuous ready and credits, one beat per cycle. Latency from yumi to link_v_o is 1 cycle.
- Credits:
  - Consumed at load (not at link handshake).
  - credits_next = credits_o - load + ret, computed in CW+1 bits; simultaneous load and token return net together.
  - If credits_next > CREDITS: credits_o<=CREDITS, overflow_o<=1 (sticky until reset).
  - credits_o never underflows: load requires credits_o≥1.
- Boundary conditions:
  - credits_o=0: no yumi even with requests. A token return in the same cycle takes effect the next cycle.
  - Single requester: granted every eligible cycle.
  - All requests low: p holds and the slot drains.
  - req_v_i may drop without being accepted; no state change results.

Test Plan:
- Reset, req_v_i=4'b1111, ready=1, token static → yumi order ch0,1,2,3,0…; link_ch_o 1 cycle later; 32 beats accepted, then credits_o=0 and yumi=0.
- From credits_o=0, toggle token_i once → credits_o=4 the next cycle; exactly 4 further beats accepted, then stall.
- ready=0 with credits=32, req_v_i[2]=1 data 16'hA5A5 → one load, link_v_o=1 held with stable data/ch=2, credits_o=31, no further yumi; ready=1 → next beat loads the same cycle (no bubble).
- Load and token toggle in the same cycle at credits_o=10 → credits_o=13.
- At credits_o=30 with idle requests, toggle token → credits_o=32, overflow_o=1 and stays 1.
- Assert rst_n low while link_v_o=1 and credits_o=5 → immediately link_v_o=0, credits_o=32, overflow_o=0, pointer back to ch0.

Source files
------------

// File: rtl/bsg_link_credit_sched.sv
// rtl/bsg_link_credit_sched.sv - credit-gated round-robin scheduler for the DDR link upstream channel
module bsg_link_credit_sched #(
    parameter int NUM_CH     = 4,
    parameter int DW         = 16,
    parameter int CREDITS    = 32,
    parameter int DECIMATION = 4,
    parameter int CW         = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           req_v_i,
    input  logic [NUM_CH*DW-1:0]        req_data_i,
    output logic [NUM_CH-1:0]           req_yumi_o,
    output logic                        link_v_o,
    output logic [DW-1:0]               link_data_o,
    output logic [$clog2(NUM_CH)-1:0]   link_ch_o,
    input  logic                        link_ready_i,
    input  logic                        token_i,
    output logic [CW-1:0]               credits_o,
    output logic                        overflow_o
);

    localparam int PW = $clog2(NUM_CH);
    localparam logic [CW:0] CREDITS_W = (CW+1)'(CREDITS);
    localparam logic [CW:0] DECIM_W   = (CW+1)'(DECIMATION);

    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     grant_idx;
    logic [PW:0]       cand_sum;
    logic [PW-1:0]     cand;
    logic              found;
    logic [NUM_CH-1:0] grant;
    logic [DW-1:0]     grant_data;
    logic              slot_free;
    logic              can_load;
    logic              tok_q;
    logic              tok_init;
    logic [CW:0]       ret;
    logic [CW:0]       credits_next;

    // Search starts at rr_ptr; the PW+1 bit sum keeps the wrap correct for non-power-of-two NUM_CH.
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        cand_sum  = '0;
        cand      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand_sum = {1'b0, rr_ptr} + (PW+1)'(k);
            if (cand_sum >= (PW+1)'(NUM_CH)) begin
                cand_sum = cand_sum - (PW+1)'(NUM_CH);
            end
            cand = cand_sum[PW-1:0];
            if (!found && req_v_i[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        grant      = '0;
        grant_data = '0;
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_idx == PW'(i)) begin
                grant_data = req_data_i[i*DW +: DW];
            end
        end
    end

    // rst_n gates the accept so nothing is consumed while the block is held in reset.
    assign slot_free  = ~link_v_o | link_ready_i;
    assign can_load   = rst_n & slot_free & (credits_o != '0) & found;
    assign req_yumi_o = grant & {NUM_CH{can_load}};

    // The first cycle after reset only captures token_i, so a static high token is not seen as an edge.
    assign ret          = (tok_init && (token_i ^ tok_q)) ? DECIM_W : '0;
    assign credits_next = {1'b0, credits_o} - {{CW{1'b0}}, can_load} + ret;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok_q    <= 1'b0;
            tok_init <= 1'b0;
        end else begin
            tok_q    <= token_i;
            tok_init <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (can_load) begin
            rr_ptr <= (grant_idx == PW'(NUM_CH-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link_v_o    <= 1'b0;
            link_data_o <= '0;
            link_ch_o   <= '0;
        end else if (can_load) begin
            link_v_o    <= 1'b1;
            link_data_o <= grant_data;
            link_ch_o   <= grant_idx;
        end else if (link_ready_i) begin
            link_v_o    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_o  <= CREDITS_W[CW-1:0];
            overflow_o <= 1'b0;
        end else if (credits_next > CREDITS_W) begin
            credits_o  <= CREDITS_W[CW-1:0];
            overflow_o <= 1'b1;
        end else begin
            credits_o  <= credits_next[CW-1:0];
        end
    end

endmodule

// File: tb/tb_bsg_link_credit_sched.sv
// tb/tb_bsg_link_credit_sched.sv - scoreboard bench for bsg_link_credit_sched
module tb_bsg_link_credit_sched;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_v;
    logic [63:0] req_data;
    logic [3:0]  req_yumi;
    logic        link_v;
    logic [15:0] link_data;
    logic [1:0]  link_ch;
    logic        link_ready;
    logic        token;
    logic [5:0]  credits;
    logic        overflow;
    logic [15:0] dat [4];

    int tests = 0;
    int fails = 0;
    logic [17:0] sb_q [$];

    bsg_link_credit_sched #(
        .NUM_CH(4), .DW(16), .CREDITS(32), .DECIMATION(4), .CW(6)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_v_i      (req_v),
        .req_data_i   (req_data),
        .req_yumi_o   (req_yumi),
        .link_v_o     (link_v),
        .link_data_o  (link_data),
        .link_ch_o    (link_ch),
        .link_ready_i (link_ready),
        .token_i      (token),
        .credits_o    (credits),
        .overflow_o   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        for (int c = 0; c < 4; c++) req_data[c*16 +: 16] = dat[c];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int ch);
        logic [1:0] c;
        c = 2'(ch);
        sb_q.push_back({c, dat[ch]});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every link handshake must match the head of the expected-beat queue.
    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && link_v && link_ready) begin
                tests++;
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("FAIL beat_unexpected actual=ch%0d/%0h required=none", link_ch, link_data);
                end else begin
                    e = sb_q.pop_front();
                    if ({link_ch, link_data} !== e) begin
                        fails++;
                        $display("FAIL beat actual=ch%0d/%0h required=ch%0d/%0h",
                                 link_ch, link_data, e[17:16], e[15:0]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_v = 4'b0000; link_ready = 1'b1; token = 1'b0;
        dat[0] = 16'h1111; dat[1] = 16'h2222; dat[2] = 16'h3333; dat[3] = 16'h4444;
        repeat (2) @(negedge clk);
        req_v = 4'b1111;
        @(negedge clk);
        chk("rst_link_v", 32'(link_v), 32'd0);
        chk("rst_data", 32'(link_data), 32'd0);
        chk("rst_ch", 32'(link_ch), 32'd0);
        chk("rst_yumi", 32'(req_yumi), 32'd0);
        chk("rst_credits", 32'(credits), 32'd32);
        chk("rst_overflow", 32'(overflow), 32'd0);

        // Round robin drains all 32 credits, then stalls.
        step(); rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk("rr_yumi", 32'(req_yumi), 32'(1 << (i % 4)));
            chk("rr_credits", 32'(credits), 32'(32 - i));
            push(i % 4);
        end
        @(negedge clk);
        chk("empty_credits", 32'(credits), 32'd0);
        chk("empty_yumi", 32'(req_yumi), 32'd0);

        // One token toggle returns four credits on the following cycle.
        step(); token = 1'b1;
        @(negedge clk);
        chk("tok_same_cycle_yumi", 32'(req_yumi), 32'd0);
        chk("tok_same_cycle_credits", 32'(credits), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("tok_yumi", 32'(req_yumi), 32'(1 << i));
            chk("tok_credits", 32'(credits), 32'(4 - i));
            push(i);
        end
        @(negedge clk);
        chk("tok_stall_yumi", 32'(req_yumi), 32'd0);
        chk("tok_stall_credits", 32'(credits), 32'd0);

        // Back-pressure: held beat stays stable, then zero-bubble reload.
        step(); req_v = 4'b0000; rst_n = 1'b0;
        step(); rst_n = 1'b1; link_ready = 1'b0; req_v = 4'b0100; dat[2] = 16'hA5A5;
        @(negedge clk);
        chk("bp_yumi", 32'(req_yumi), 32'b0100);
        push(2);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("bp_v", 32'(link_v), 32'd1);
            chk("bp_ch", 32'(link_ch), 32'd2);
            chk("bp_data", 32'(link_data), 32'hA5A5);
            chk("bp_credits", 32'(credits), 32'd31);
            chk("bp_no_yumi", 32'(req_yumi), 32'd0);
        end
        step(); link_ready = 1'b1; dat[2] = 16'h5A5A;
        @(negedge clk);
        chk("nobubble_yumi", 32'(req_yumi), 32'b0100);
        push(2);
        step(); req_v = 4'b0000;
        @(negedge clk);
        chk("nobubble_data", 32'(link_data), 32'h5A5A);
        chk("nobubble_credits", 32'(credits), 32'd30);
        @(negedge clk);
        chk("drain_v", 32'(link_v), 32'd0);

        // Single requester down to 10 credits, then load and token in the same cycle.
        step(); req_v = 4'b0010;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("single_yumi", 32'(req_yumi), 32'b0010);
            push(1);
        end
        step(); token = 1'b0;
        @(negedge clk);
        chk("net_pre_credits", 32'(credits), 32'd10);
        chk("net_yumi", 32'(req_yumi), 32'b0010);
        push(1);
        step(); req_v = 4'b0000;
        @(negedge clk);
        chk("net_credits", 32'(credits), 32'd13);

        // Bring credits to 30, then overflow by one toggle.
        step(); req_v = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("pre_ovf_credits", 32'(credits), 32'(13 - i));
            push(1);
        end
        step(); req_v = 4'b0000; token = ~token;
        for (int i = 0; i < 4; i++) begin
            step(); token = ~token;
        end
        repeat (2) @(negedge clk);
        chk("c30_credits", 32'(credits), 32'd30);
        chk("c30_overflow", 32'(overflow), 32'd0);
        step(); token = ~token;
        repeat (2) @(negedge clk);
        chk("ovf_credits", 32'(credits), 32'd32);
        chk("ovf_flag", 32'(overflow), 32'd1);
        repeat (3) @(negedge clk);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // 27 loads leave 5 credits; the last beat is held and then discarded by reset.
        step(); req_v = 4'b0010;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            chk("pre_rst_credits", 32'(credits), 32'(32 - i));
            if (i < 26) push(1);
        end
        step(); req_v = 4'b0000; link_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_v", 32'(link_v), 32'd1);
        chk("pre_rst_c5", 32'(credits), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_v", 32'(link_v), 32'd0);
        chk("async_rst_credits", 32'(credits), 32'd32);
        chk("async_rst_overflow", 32'(overflow), 32'd0);
        req_v = 4'b1111;
        @(negedge clk);
        chk("async_rst_yumi", 32'(req_yumi), 32'd0);
        step(); rst_n = 1'b1; link_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_ptr", 32'(req_yumi), 32'b0001);
        push(0);
        step(); req_v = 4'b0000;
        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
